// File: rtl/serial_comparator.sv
// -----------------------------------------------------------------------------
// serial_comparator
//
// Multi-cycle magnitude comparator for WIDTH-bit operands. The operands are
// walked MSB-first, SLICE bits per clock, and the walk stops at the first
// slice that differs. Unsigned or two's-complement order is chosen per
// operation. The registered one-hot less/equal/greater result holds until the
// next decision.
//
// Parameters
//   WIDTH     : operand width in bits (>= 2)
//   SLICE     : bits compared per clock (1..WIDTH, WIDTH % SLICE == 0)
//   SIGNED_EN : 1 = signed_mode honoured, 0 = always unsigned
//
// Ports
//   sys_clk     in   system clock, rising edge
//   sys_rst_n   in   asynchronous active-low reset
//   start       in   compare request, sampled only in IDLE
//   signed_mode in   1 = two's-complement compare, sampled with start
//   num1, num2  in   operands, sampled with start
//   busy        out  high while the compare is running
//   done        out  one-cycle pulse when a result is published
//   less        out  num1 <  num2 for the last completed operation
//   equal       out  num1 == num2 for the last completed operation
//   greater     out  num1 >  num2 for the last completed operation
// -----------------------------------------------------------------------------
module serial_comparator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned SLICE     = 2,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic             less,
  output logic             equal,
  output logic             greater
);

  localparam int unsigned N  = WIDTH / SLICE;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  // Sign-bit position; flipping it maps two's-complement onto offset binary.
  localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] flip_c;
  logic [SLICE-1:0] a_top_c;
  logic [SLICE-1:0] b_top_c;

  // MSB inversion applied at capture so the slice walk is always unsigned.
  assign flip_c  = (SIGNED_EN && signed_mode) ? MSB_MASK : '0;

  // Slice currently under comparison sits at the top of the shift registers.
  assign a_top_c = a[WIDTH-1 -: SLICE];
  assign b_top_c = b[WIDTH-1 -: SLICE];

  // Control FSM, operand shifters and registered result flags.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      a       <= '0;
      b       <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      less    <= 1'b0;
      equal   <= 1'b0;
      greater <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a     <= num1 ^ flip_c;
            b     <= num2 ^ flip_c;
            cnt   <= CW'(N - 1);
            busy  <= 1'b1;
            state <= RUN;
          end
        end

        RUN: begin
          if (a_top_c != b_top_c) begin
            // First differing slice decides the order.
            less    <= (a_top_c < b_top_c);
            greater <= (a_top_c > b_top_c);
            equal   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (cnt == '0) begin
            less    <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            a   <= a << SLICE;
            b   <= b << SLICE;
            cnt <= cnt - CW'(1);
          end
        end

        DONE: begin
          // start is deliberately not looked at here: no queuing.
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comparator.sv
// -----------------------------------------------------------------------------
// tb_serial_comparator
//
// Three comparator instances sharing one clock/reset:
//   unit 0 : WIDTH=8, SLICE=2, SIGNED_EN=1
//   unit 1 : WIDTH=2, SLICE=1, SIGNED_EN=0
//   unit 2 : WIDTH=4, SLICE=4, SIGNED_EN=1
// Expected results are pushed to a scoreboard queue when a start is driven and
// popped when the matching done pulse appears.
// -----------------------------------------------------------------------------
module tb_serial_comparator;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  logic       start0, sm0, busy0, done0, less0, equal0, greater0;
  logic [7:0] n1_0, n2_0;
  logic       start1, sm1, busy1, done1, less1, equal1, greater1;
  logic [1:0] n1_1, n2_1;
  logic       start2, sm2, busy2, done2, less2, equal2, greater2;
  logic [3:0] n1_2, n2_2;

  serial_comparator #(.WIDTH(8), .SLICE(2), .SIGNED_EN(1'b1)) u0 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start0), .signed_mode(sm0),
    .num1(n1_0), .num2(n2_0), .busy(busy0), .done(done0),
    .less(less0), .equal(equal0), .greater(greater0));

  serial_comparator #(.WIDTH(2), .SLICE(1), .SIGNED_EN(1'b0)) u1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start1), .signed_mode(sm1),
    .num1(n1_1), .num2(n2_1), .busy(busy1), .done(done1),
    .less(less1), .equal(equal1), .greater(greater1));

  serial_comparator #(.WIDTH(4), .SLICE(4), .SIGNED_EN(1'b1)) u2 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start2), .signed_mode(sm2),
    .num1(n1_2), .num2(n2_2), .busy(busy2), .done(done2),
    .less(less2), .equal(equal2), .greater(greater2));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [2:0] leg;   // {less, equal, greater}
    int         lat;   // decision edge relative to the start edge
  } exp_t;

  exp_t sb[$];

  function automatic int unit_w(int u);
    return (u == 0) ? 8 : ((u == 1) ? 2 : 4);
  endfunction

  function automatic int unit_s(int u);
    return (u == 0) ? 2 : ((u == 1) ? 1 : 4);
  endfunction

  function automatic bit unit_se(int u);
    return (u != 1);
  endfunction

  // Reference: integer compare plus first-differing-slice latency.
  function automatic exp_t model(int u, logic [7:0] x1, logic [7:0] x2, logic sgn);
    exp_t e;
    int   w    = unit_w(u);
    int   s    = unit_s(u);
    int   n    = w / s;
    int   mask = (1 << w) - 1;
    int   v1   = int'(x1) & mask;
    int   v2   = int'(x2) & mask;
    int   x    = v1 ^ v2;
    bit   found = 0;
    if (sgn && unit_se(u)) begin
      if (v1 >= (1 << (w - 1))) v1 = v1 - (1 << w);
      if (v2 >= (1 << (w - 1))) v2 = v2 - (1 << w);
    end
    e.leg = (v1 < v2) ? 3'b100 : ((v1 == v2) ? 3'b010 : 3'b001);
    e.lat = n;
    for (int j = 0; j < n; j++) begin
      if (!found && (((x >> (w - (j + 1) * s)) & ((1 << s) - 1)) != 0)) begin
        e.lat = j + 1;
        found = 1;
      end
    end
    return e;
  endfunction

  // {busy, done, less, equal, greater}
  function automatic logic [4:0] obs(int u);
    case (u)
      0:       return {busy0, done0, less0, equal0, greater0};
      1:       return {busy1, done1, less1, equal1, greater1};
      default: return {busy2, done2, less2, equal2, greater2};
    endcase
  endfunction

  task automatic drive(int u, logic st, logic [7:0] x1, logic [7:0] x2, logic sg);
    case (u)
      0: begin start0 = st; n1_0 = x1; n2_0 = x2; sm0 = sg; end
      1: begin start1 = st; n1_1 = x1[1:0]; n2_1 = x2[1:0]; sm1 = sg; end
      default: begin start2 = st; n1_2 = x1[3:0]; n2_2 = x2[3:0]; sm2 = sg; end
    endcase
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One full operation: start, wait for done, check result/latency/busy time,
  // then check that done drops and the result holds.
  task automatic run_op(int u, logic [7:0] x1, logic [7:0] x2, logic sg, string tag);
    exp_t       e;
    logic [4:0] o;
    bit         seen = 0;
    int         k;
    int         busy_cnt = 0;
    e.leg = 3'b000;
    e.lat = 0;
    sb.push_back(model(u, x1, x2, sg));
    drive(u, 1'b1, x1, x2, sg);
    tick();
    // Inputs scrambled after the start edge must not disturb the operation.
    drive(u, 1'b0, ~x1, ~x2, ~sg);
    o = obs(u);
    busy_cnt += int'(o[4]);
    for (k = 1; k <= 20; k++) begin
      tick();
      o = obs(u);
      if (o[3]) begin
        seen = 1;
        break;
      end
      busy_cnt += int'(o[4]);
    end
    checks++;
    if (!seen) begin
      errors++;
      void'(sb.pop_front());
      $display("FAIL %s timeout: no done within 20 edges", tag);
    end else begin
      e = sb.pop_front();
      if (o[2:0] !== e.leg || k != e.lat || busy_cnt != e.lat || o[4] !== 1'b0) begin
        errors++;
        $display("FAIL %s result: leg=%b edge=%0d busy_cycles=%0d busy=%b, expected leg=%b edge=%0d busy_cycles=%0d busy=0",
                 tag, o[2:0], k, busy_cnt, o[4], e.leg, e.lat, e.lat);
      end
    end
    tick();
    o = obs(u);
    checks++;
    if (o[3] !== 1'b0 || o[4] !== 1'b0 || (seen && o[2:0] !== e.leg)) begin
      errors++;
      $display("FAIL %s post_done: busy=%b done=%b leg=%b, expected busy=0 done=0 leg=%b",
               tag, o[4], o[3], o[2:0], e.leg);
    end
  endtask

  task automatic test_reset();
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (obs(u) !== 5'b00000) begin
        errors++;
        $display("FAIL reset_u%0d: outputs=%b expected 00000", u, obs(u));
      end
    end
  endtask

  task automatic test_equal();
    run_op(0, 8'hA5, 8'hA5, 1'b0, "equal_a5");
    run_op(0, 8'h00, 8'h00, 1'b1, "equal_zero_signed");
  endtask

  task automatic test_signed();
    run_op(0, 8'h80, 8'h7F, 1'b0, "unsigned_80_7f");
    run_op(0, 8'h80, 8'h7F, 1'b1, "signed_80_7f");
    run_op(0, 8'hFF, 8'h01, 1'b1, "signed_m1_1");
    run_op(0, 8'hFE, 8'hFF, 1'b1, "signed_m2_m1");
  endtask

  task automatic test_early_exit();
    logic [4:0] o;
    int         bad = 0;
    run_op(0, 8'h3C, 8'h3D, 1'b0, "exit_slice3");
    run_op(0, 8'h34, 8'h3C, 1'b0, "exit_slice2");
    for (int t = 0; t < 5; t++) begin
      tick();
      o = obs(0);
      if (o !== 5'b00100) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_idle: outputs=%b in %0d idle cycles, expected 00100", o, bad);
    end
  endtask

  task automatic test_ignore_start();
    exp_t e;
    int   dones = 0;
    int   first = -1;
    logic [2:0] leg_at_done = 3'b000;
    bit   busy_ok = 0;
    e.leg = 3'b000;
    e.lat = 0;
    sb.push_back(model(0, 8'hA5, 8'hA5, 1'b0));
    drive(0, 1'b1, 8'hA5, 8'hA5, 1'b0);
    for (int t = 0; t <= 12; t++) begin
      tick();
      if (done0) begin
        dones++;
        if (first < 0) begin
          first = t;
          leg_at_done = {less0, equal0, greater0};
          e = sb.pop_front();
        end
      end
      if (t == 1) busy_ok = busy0;
      // start held through edge 1 (RUN), raised again in DONE.
      if (t == 2) start0 = 1'b0;
      if (first >= 0 && t == first) start0 = 1'b1;
      if (first >= 0 && t == first + 1) start0 = 1'b0;
    end
    if (first < 0) void'(sb.pop_front());
    checks++;
    if (dones != 1 || first != 4 || !busy_ok) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d first_edge=%0d busy_e1=%b, expected 1 at edge 4 busy 1",
               dones, first, busy_ok);
    end
    checks++;
    if (leg_at_done !== e.leg || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ignore_start_leg: leg=%b busy=%b, expected leg=%b busy=0", leg_at_done, busy0, e.leg);
    end
  endtask

  task automatic test_back_to_back();
    int   edges[$];
    int   bad_leg = 0;
    exp_t e;
    sb.push_back(model(0, 8'h80, 8'h7F, 1'b0));
    sb.push_back(model(0, 8'h80, 8'h7F, 1'b1));
    sb.push_back(model(0, 8'h55, 8'h55, 1'b0));
    drive(0, 1'b1, 8'h80, 8'h7F, 1'b0);
    for (int t = 0; t <= 14; t++) begin
      tick();
      if (done0) begin
        edges.push_back(t);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          if ({less0, equal0, greater0} !== e.leg) bad_leg++;
        end else begin
          bad_leg++;
        end
      end
      if (t == 0) drive(0, 1'b1, 8'h80, 8'h7F, 1'b1);
      if (t == 3) drive(0, 1'b1, 8'h55, 8'h55, 1'b0);
      if (t == 6) start0 = 1'b0;
    end
    while (sb.size() > 0) void'(sb.pop_front());
    checks++;
    if (edges.size() != 3 || edges[0] != 1 || edges[1] != 4 || edges[2] != 10) begin
      errors++;
      $display("FAIL back_to_back_timing: %0d dones, edges=%p, expected 3 at 1 4 10", edges.size(), edges);
    end
    checks++;
    if (bad_leg != 0) begin
      errors++;
      $display("FAIL back_to_back_leg: %0d wrong results, expected 0", bad_leg);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    drive(0, 1'b1, 8'hA5, 8'hA5, 1'b0);
    tick();
    start0 = 1'b0;
    tick();
    tick();
    sys_rst_n = 1'b0;
    #1;
    checks++;
    if (obs(0) !== 5'b00000) begin
      errors++;
      $display("FAIL reset_mid_async: outputs=%b expected 00000", obs(0));
    end
    tick();
    tick();
    sys_rst_n = 1'b1;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (done0 || busy0) dones++;
    end
    checks++;
    if (dones != 0 || obs(0) !== 5'b00000) begin
      errors++;
      $display("FAIL reset_mid_abort: busy/done seen %0d times, outputs=%b, expected 0 and 00000",
               dones, obs(0));
    end
    run_op(0, 8'h12, 8'h34, 1'b0, "after_reset");
  endtask

  task automatic test_random_u0();
    for (int i = 0; i < 12; i++) begin
      run_op(0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)), "rand_u0");
    end
  endtask

  task automatic test_truth_table_u1();
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run_op(1, 8'(x), 8'(y), 1'($urandom_range(0, 1)), "tt_2bit");
      end
    end
  endtask

  task automatic test_full_slice_u2();
    run_op(2, 8'h08, 8'h07, 1'b0, "full_unsigned_8_7");
    run_op(2, 8'h08, 8'h07, 1'b1, "full_signed_8_7");
    run_op(2, 8'h05, 8'h05, 1'b0, "full_equal");
    for (int i = 0; i < 6; i++) begin
      run_op(2, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)),
             1'($urandom_range(0, 1)), "full_rand");
    end
  endtask

  initial begin
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 8'h00, 1'b0);
    drive(2, 1'b0, 8'h00, 8'h00, 1'b0);
    tick();
    tick();
    test_reset();
    sys_rst_n = 1'b1;
    tick();
    test_reset();
    test_equal();
    test_signed();
    test_early_exit();
    test_ignore_start();
    tick();
    test_back_to_back();
    tick();
    test_reset_mid();
    test_random_u0();
    test_truth_table_u1();
    test_full_slice_u2();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a wait above ever stalls the bench.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/serial_comparator.md
Name: serial_comparator

Overview:
Parametrised magnitude comparator for WIDTH-bit operands, processed MSB-first, SLICE bits per clock, with a start/busy/done handshake.
- Supports unsigned and two's-complement signed compare, selected per operation.
- Exits early on the first differing slice.
- Registers one-hot less/equal/greater results that hold between operations.
- Sits between operand sources (counters, key/ADC capture) and control FSMs that need ordered compare results without a wide combinational comparator.

Parameters:
- WIDTH, 8, operand width in bits; >= 2.
- SLICE, 2, bits compared per clock; 1 <= SLICE <= WIDTH; WIDTH must be a multiple of SLICE.
- SIGNED_EN, 1, 1 = signed_mode input honoured; 0 = signed_mode ignored, always unsigned.

Ports:
- sys_clk, input, 1, system clock; all state updates on rising edge.
- sys_rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a compare; sampled only in IDLE.
- signed_mode, input, 1, 1 = two's-complement compare; sampled with start.
- num1, input, WIDTH, first operand; sampled with start.
- num2, input, WIDTH, second operand; sampled with start.
- busy, output, 1, high while in RUN.
- done, output, 1, single-cycle pulse when a result is published.
- less, output, 1, num1 < num2 for the last completed operation.
- equal, output, 1, num1 == num2 for the last completed operation.
- greater, output, 1, num1 > num2 for the last completed operation.

Behaviour:
- Reset (async, sys_rst_n = 0):
  - FSM goes to IDLE.
  - busy, done, less, equal, greater = 0.
  - Operand registers and slice counter cleared.
  - Reset mid-operation aborts it; no done pulse.
- FSM states: IDLE, RUN, DONE; N = WIDTH/SLICE.
- IDLE:
  - On an edge with start = 1: latch num1/num2 into shift registers a/b and load slice counter = N-1; go to RUN.
  - If signed_mode = 1 and SIGNED_EN = 1, invert the MSB of both latched operands (offset-binary), so the unsigned slice compare yields the signed order.
- RUN, each edge:
  - Compare a[WIDTH-1 -: SLICE] against b[WIDTH-1 -: SLICE] as unsigned.
  - If they differ: set less or greater per the slice relation, clear the other two result bits, and go to DONE.
  - Else if counter = 0: set equal = 1, clear less/greater, and go to DONE.
  - Else: shift a and b left by SLICE, decrement the counter, and stay in RUN.
- DONE:
  - done = 1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
  - start is ignored in DONE.
- Handshake:
  - start is ignored in RUN and DONE; no queuing.
  - A start held high continuously is accepted again on the first IDLE edge, giving back-to-back ops with a 1-cycle IDLE gap.
- busy = 1 exactly while the state is RUN.
- Latency (start sampled at edge 0):
  - A first difference in slice j (0 = MS slice) causes a decision at edge j+1, with done high between edges j+1 and j+2.
  - Equal operands take the maximum: decision at edge N.
  - With SLICE = WIDTH, the decision is at edge 1.
- Results:
  - less/equal/greater change only on decision edges.
  - They are one-hot after the first completed operation and hold until the next decision.
  - They are all 0 from reset until the first decision.
- num1/num2/signed_mode changes after the start edge have no effect on the running operation.
- The MSB inversion applies to the whole operand: with SLICE > 1, the top slice compare includes the inverted sign bit.

Test Plan:
- WIDTH=8, SLICE=2, unsigned: 0xA5 vs 0xA5 -> busy for 4 cycles, done pulse after edge 4; equal=1, less=greater=0.
- 0x80 vs 0x7F, signed_mode=0 -> decision at edge 1, greater=1; repeat with signed_mode=1 -> less=1, done after edge 1.
- 0x3C vs 0x3D, unsigned -> early exit at slice 3 (edge 4), less=1. Then 0x34 vs 0x3C -> exit at slice 2 (edge 3), less=1; results held through a following IDLE period.
- Assert start during RUN and during DONE -> ignored; exactly one done per accepted start. Hold start high for 3 ops -> 3 done pulses, each separated by the IDLE gap.
- Drop sys_rst_n mid-RUN (edge 2 of 4) -> busy, done and results immediately 0; no done pulse; a new start after release compares correctly.
- WIDTH=2, SLICE=1, SIGNED_EN=0: all 16 num1/num2 pairs -> outputs match the 2-bit unsigned less/equal/greater truth table. WIDTH=4, SLICE=4 -> every result at edge 1.
